// File: rtl/fp_mult_arbiter.sv
// Arbitrates N requesters onto one pipelined FP multiplier and routes products back by tag.
// Define FP_MULT_ARB_FIXED_PRIO_EN for fixed-priority grant; default is round-robin.
module fp_mult_arbiter #(
    parameter int pNumReq   = 4,
    parameter int pWidthExp = 11,
    parameter int pWidthMan = 52,
    parameter int pPipeline = 5,
    localparam int W = pWidthExp + pWidthMan + 1
) (
    input  logic                 i_Clk,
    input  logic                 i_RstN,
    input  logic [pNumReq-1:0]   iv_ReqValid,
    output logic [pNumReq-1:0]   ov_ReqReady,
    input  logic [pNumReq*W-1:0] iv_ReqA,
    input  logic [pNumReq*W-1:0] iv_ReqB,
    output logic [W-1:0]         ov_MultA,
    output logic [W-1:0]         ov_MultB,
    output logic                 o_MultDv,
    input  logic [2:0]           i3_MultInID,
    input  logic [W-1:0]         iv_MultResult,
    input  logic [2:0]           i3_MultOutID,
    input  logic                 i_MultOf,
    input  logic                 i_MultUf,
    input  logic                 i_MultNaN,
    output logic [pNumReq-1:0]   ov_RspValid,
    output logic [W-1:0]         ov_RspData,
    output logic                 o_RspOf,
    output logic                 o_RspUf,
    output logic                 o_RspNaN,
    input  logic                 i_Flush,
    output logic                 o_FlushDone,
    output logic                 o_IdErr,
    output logic [2:0]           o3_Outstanding
);

    localparam int IW = (pNumReq > 1) ? $clog2(pNumReq) : 1;

    if (pNumReq < 2 || pNumReq > 7 || pPipeline < 1 || pPipeline > 6) begin : g_bad_cfg
        $error("fp_mult_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t             state_q;
    logic [2:0]         cnt_q;
    logic               mult_dv_q;
    logic [W-1:0]       mult_a_q, mult_b_q;
    logic [IW-1:0]      mult_src_q;
    logic [pNumReq-1:0] rsp_valid_q;
    logic [W-1:0]       rsp_data_q;
    logic               of_q, uf_q, nan_q, iderr_q;
    logic [7:1]         tag_vld_q;
    logic [IW-1:0]      tag_req_q [1:7];

    logic               can_issue;
    logic [pNumReq-1:0] grant;
    logic [IW-1:0]      gnt_idx;
    logic               xfer;
    logic [W-1:0]       sel_a, sel_b;
    logic               hit, miss;

    assign can_issue = (state_q == RUN) && !i_Flush && (cnt_q != 3'd7);

`ifdef FP_MULT_ARB_FIXED_PRIO_EN
    always_comb begin
        logic found;
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < pNumReq; i++) begin
            if (!found && iv_ReqValid[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gnt_idx  = IW'(i);
            end
        end
        if (!can_issue) grant = '0;
    end
`else
    logic [IW-1:0] ptr_q;

    // Search starts at ptr_q, the index after the last winner.
    always_comb begin
        logic          found;
        logic [IW:0]   sum;
        logic [IW-1:0] idx;
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < pNumReq; i++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(i);
            if (sum >= (IW+1)'(pNumReq)) sum = sum - (IW+1)'(pNumReq);
            idx = sum[IW-1:0];
            if (!found && iv_ReqValid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = idx;
            end
        end
        if (!can_issue) grant = '0;
    end
`endif

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < pNumReq; k++) begin
            if (grant[k]) begin
                sel_a = iv_ReqA[k*W +: W];
                sel_b = iv_ReqB[k*W +: W];
            end
        end
    end

    assign xfer = |grant;
    assign hit  = (i3_MultOutID != 3'd0) && tag_vld_q[i3_MultOutID];
    assign miss = (i3_MultOutID != 3'd0) && !tag_vld_q[i3_MultOutID];

    always_ff @(posedge i_Clk) begin
        if (!i_RstN) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            mult_dv_q   <= 1'b0;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            mult_src_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            of_q        <= 1'b0;
            uf_q        <= 1'b0;
            nan_q       <= 1'b0;
            iderr_q     <= 1'b0;
            tag_vld_q   <= '0;
`ifndef FP_MULT_ARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            mult_dv_q <= xfer;
            if (xfer) begin
                mult_a_q   <= sel_a;
                mult_b_q   <= sel_b;
                mult_src_q <= gnt_idx;
`ifndef FP_MULT_ARB_FIXED_PRIO_EN
                if (gnt_idx == IW'(pNumReq - 1)) ptr_q <= '0;
                else                             ptr_q <= gnt_idx + 1'b1;
`endif
            end

            iderr_q     <= miss || (mult_dv_q && (i3_MultInID == 3'd0));
            rsp_valid_q <= '0;
            if (hit) begin
                rsp_valid_q[tag_req_q[i3_MultOutID]] <= 1'b1;
                rsp_data_q <= iv_MultResult;
                of_q       <= i_MultOf;
                uf_q       <= i_MultUf;
                nan_q      <= i_MultNaN;
                tag_vld_q[i3_MultOutID] <= 1'b0;
            end
            // A new tag written on the same index as a retiring one wins.
            if (mult_dv_q && (i3_MultInID != 3'd0)) begin
                tag_vld_q[i3_MultInID] <= 1'b1;
                tag_req_q[i3_MultInID] <= mult_src_q;
            end

            unique case ({xfer, hit})
                2'b10:   if (cnt_q != 3'd7) cnt_q <= cnt_q + 3'd1;
                2'b01:   if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
                default: ;
            endcase

            unique case (state_q)
                RUN:     if (i_Flush) state_q <= DRAIN;
                DRAIN:   if (cnt_q == 3'd0 && !mult_dv_q) state_q <= DONE;
                DONE:    if (!i_Flush) state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign ov_ReqReady    = grant;
    assign ov_MultA       = mult_a_q;
    assign ov_MultB       = mult_b_q;
    assign o_MultDv       = mult_dv_q;
    assign ov_RspValid    = rsp_valid_q;
    assign ov_RspData     = rsp_data_q;
    assign o_RspOf        = of_q;
    assign o_RspUf        = uf_q;
    assign o_RspNaN       = nan_q;
    assign o_IdErr        = iderr_q;
    assign o_FlushDone    = (state_q == DONE);
    assign o3_Outstanding = cnt_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Scoreboard bench for fp_mult_arbiter: random traffic against a queue-based reference
// model, a tagged multiplier stub, plus flush, back-pressure, bad-ID and reset scenarios.
module tb_fp_mult_arbiter;

    localparam int N   = 4;
    localparam int W   = 64;
    localparam int LAT = 5;

    logic           clk = 1'b0;
    logic           i_RstN = 1'b0;
    logic [N-1:0]   iv_ReqValid = '0;
    logic [N-1:0]   ov_ReqReady;
    logic [N*W-1:0] iv_ReqA = '0;
    logic [N*W-1:0] iv_ReqB = '0;
    logic [W-1:0]   ov_MultA, ov_MultB;
    logic           o_MultDv;
    logic [2:0]     i3_MultInID = '0;
    logic [W-1:0]   iv_MultResult = '0;
    logic [2:0]     i3_MultOutID = '0;
    logic           i_MultOf = 1'b0, i_MultUf = 1'b0, i_MultNaN = 1'b0;
    logic [N-1:0]   ov_RspValid;
    logic [W-1:0]   ov_RspData;
    logic           o_RspOf, o_RspUf, o_RspNaN;
    logic           i_Flush = 1'b0;
    logic           o_FlushDone, o_IdErr;
    logic [2:0]     o3_Outstanding;

    fp_mult_arbiter #(
        .pNumReq(N), .pWidthExp(11), .pWidthMan(52), .pPipeline(LAT)
    ) dut (
        .i_Clk(clk), .i_RstN(i_RstN),
        .iv_ReqValid(iv_ReqValid), .ov_ReqReady(ov_ReqReady),
        .iv_ReqA(iv_ReqA), .iv_ReqB(iv_ReqB),
        .ov_MultA(ov_MultA), .ov_MultB(ov_MultB), .o_MultDv(o_MultDv),
        .i3_MultInID(i3_MultInID), .iv_MultResult(iv_MultResult),
        .i3_MultOutID(i3_MultOutID),
        .i_MultOf(i_MultOf), .i_MultUf(i_MultUf), .i_MultNaN(i_MultNaN),
        .ov_RspValid(ov_RspValid), .ov_RspData(ov_RspData),
        .o_RspOf(o_RspOf), .o_RspUf(o_RspUf), .o_RspNaN(o_RspNaN),
        .i_Flush(i_Flush), .o_FlushDone(o_FlushDone),
        .o_IdErr(o_IdErr), .o3_Outstanding(o3_Outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] oh;
        logic [W-1:0] d;
        logic [2:0]   fl;
        int           due;
    } exp_t;

    typedef struct {
        int           due;
        logic [2:0]   id;
        logic [W-1:0] d;
        logic [2:0]   fl;
    } pend_t;

    exp_t  sb[$];
    pend_t pq[$];
    bit    id_busy [1:7];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ptr = 0;
    int mul_lat = LAT;
    logic flush_prev = 1'b0;
    logic iderr_ok = 1'b0;
    logic [2:0] inj_id = '0;
    logic fix_en = 1'b0;
    logic [W-1:0] fix_a = '0, fix_b = '0;

    function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    // Stub flag pattern {of, uf, nan}: arbitrary but operand-dependent.
    function automatic logic [2:0] fflags(input logic [W-1:0] a, input logic [W-1:0] b);
        return {a[0] & b[0], a[1] ^ b[1], a[2] | b[2]};
    endfunction

    function automatic logic [W-1:0] rand_fp();
        logic [W-1:0] r;
        r = {$urandom, $urandom};
        r[62:52] = 11'h3F0 + 11'($urandom_range(0, 31));
        return r;
    endfunction

    function automatic int pick(input logic [N-1:0] v);
        int j;
`ifdef FP_MULT_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (((v >> i) & 1) != 0) return i;
`else
        for (int i = 0; i < N; i++) begin
            j = (ptr + i) % N;
            if (((v >> j) & 1) != 0) return j;
        end
`endif
        return -1;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stub: assigns tags, returns products mul_lat cycles after issue.
    always @(posedge clk) begin
        pend_t p;
        int    id;
        #1;
        i3_MultOutID = '0;
        i3_MultInID  = '0;
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            p = pq.pop_front();
            i3_MultOutID  = p.id;
            iv_MultResult = p.d;
            {i_MultOf, i_MultUf, i_MultNaN} = p.fl;
            id_busy[p.id] = 1'b0;
        end else if (inj_id != 3'd0) begin
            i3_MultOutID = inj_id;
        end
        if (o_MultDv) begin
            id = 0;
            for (int i = 1; i < 8; i++) if (id == 0 && !id_busy[i]) id = i;
            if (id != 0) begin
                id_busy[id] = 1'b1;
                i3_MultInID = 3'(id);
                p.due = cyc + mul_lat;
                p.id  = 3'(id);
                p.d   = fmul(ov_MultA, ov_MultB);
                p.fl  = fflags(ov_MultA, ov_MultB);
                pq.push_back(p);
            end
        end
    end

    // Response monitor: pops the scoreboard on every response strobe.
    always @(negedge clk) begin
        exp_t e;
        if (ov_RspValid != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got %b expected none", ov_RspValid);
            end else begin
                e = sb.pop_front();
                check("rsp_valid", W'(ov_RspValid), W'(e.oh));
                check("rsp_data", ov_RspData, e.d);
                check("rsp_flags", W'({o_RspOf, o_RspUf, o_RspNaN}), W'(e.fl));
                check("rsp_latency", W'(cyc), W'(e.due));
            end
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got none expected %b due %0d", sb[0].oh, sb[0].due);
            void'(sb.pop_front());
        end
        if (!iderr_ok && i_RstN) check("iderr_idle", W'(o_IdErr), '0);
    end

    task automatic step(input logic [N-1:0] vmask, input logic flush);
        logic [W-1:0] opa [N];
        logic [W-1:0] opb [N];
        logic [N-1:0] exp_rdy;
        exp_t e;
        int g;
        @(posedge clk);
        #2;
        iv_ReqValid = vmask;
        i_Flush = flush;
        for (int k = 0; k < N; k++) begin
            opa[k] = rand_fp();
            opb[k] = rand_fp();
        end
        if (fix_en) begin
            opa[0] = fix_a;
            opb[0] = fix_b;
        end
        for (int k = 0; k < N; k++) begin
            iv_ReqA[k*W +: W] = opa[k];
            iv_ReqB[k*W +: W] = opb[k];
        end
        @(negedge clk);
        #1;
        exp_rdy = '0;
        g = -1;
        if (!flush && !flush_prev && sb.size() < 7) g = pick(vmask);
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", W'(ov_ReqReady), W'(exp_rdy));
        check("outstanding", W'(o3_Outstanding), W'(sb.size()));
        if (g >= 0) begin
            e.oh  = exp_rdy;
            e.d   = fmul(opa[g], opb[g]);
            e.fl  = fflags(opa[g], opb[g]);
            e.due = cyc + 2 + mul_lat;
            sb.push_back(e);
            ptr = (g + 1) % N;
        end
        flush_prev = flush;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() > 0 || pq.size() > 0) && n < 100) begin
            step('0, 1'b0);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        i_RstN = 1'b0;
        iv_ReqValid = '0;
        i_Flush = 1'b0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst_multdv", W'(o_MultDv), '0);
        check("rst_multa", ov_MultA, '0);
        check("rst_multb", ov_MultB, '0);
        check("rst_rspvalid", W'(ov_RspValid), '0);
        check("rst_rspdata", ov_RspData, '0);
        check("rst_flags", W'({o_RspOf, o_RspUf, o_RspNaN}), '0);
        check("rst_iderr", W'(o_IdErr), '0);
        check("rst_flushdone", W'(o_FlushDone), '0);
        check("rst_outstanding", W'(o3_Outstanding), '0);
        @(posedge clk);
        #2;
        i_RstN = 1'b1;
        ptr = 0;
        flush_prev = 1'b0;
    endtask

    initial begin
        int n;
        int pulses;
        for (int i = 1; i < 8; i++) id_busy[i] = 1'b0;
        do_reset();

        // Single 1.0 * 1.5 operation from requester 0.
        fix_en = 1'b1;
        fix_a = 64'h3FF0000000000000;
        fix_b = 64'h3FF8000000000000;
        step(4'b0001, 1'b0);
        fix_en = 1'b0;
        drain();

        // All requesters valid for 8 cycles.
        do_reset();
        for (int i = 0; i < 8; i++) begin
`ifdef FP_MULT_ARB_FIXED_PRIO_EN
            step(4'b0101, 1'b0);
            check("fixed_prio_grant", W'(ov_ReqReady), 64'd1);
`else
            step(4'b1111, 1'b0);
            check("rr_grant_order", W'(ov_ReqReady), W'(1 << (i % 4)));
`endif
        end
        drain();

        // Slow multiplier: back-pressure at 7 outstanding.
        mul_lat = 20;
        for (int i = 0; i < 30; i++) begin
            step(4'b1111, 1'b0);
            if (i == 7) begin
                check("full_ready", W'(ov_ReqReady), '0);
                check("full_count", W'(o3_Outstanding), 64'd7);
            end
        end
        drain();
        mul_lat = LAT;

        // Random traffic.
        for (int i = 0; i < 200; i++) step(N'($urandom), 1'b0);
        drain();

        // Flush with three in flight.
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0);
        step(4'b1111, 1'b1);
        check("flushdone_early", W'(o_FlushDone), '0);
        n = 0;
        while (!o_FlushDone && n < 40) begin
            step(4'b1111, 1'b1);
            n++;
        end
        check("flushdone_set", W'(o_FlushDone), 64'd1);
        check("flush_drained", W'(sb.size()), '0);
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        check("flush_resume", W'(o_FlushDone), '0);
        check("flush_regrant", W'(ov_ReqReady != '0), 64'd1);
        drain();

        // Result tagged with an unmapped ID while two are in flight.
        iderr_ok = 1'b1;
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        inj_id = 3'd5;
        step('0, 1'b0);
        inj_id = 3'd0;
        step('0, 1'b0);
        check("bad_id_pulse", W'(o_IdErr), 64'd1);
        check("bad_id_norsp", W'(ov_RspValid), '0);
        check("bad_id_count", W'(o3_Outstanding), 64'd2);
        step('0, 1'b0);
        check("bad_id_oneshot", W'(o_IdErr), '0);
        drain();

        // Reset with three in flight: late results must be flagged, not routed.
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0);
        step('0, 1'b0);
        do_reset();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step('0, 1'b0);
            if (o_IdErr) pulses++;
        end
        check("orphan_iderr", W'(pulses), 64'd3);
        iderr_ok = 1'b0;
        step(4'b0100, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_mult_arbiter.md
FP_MULT_ARBITER -- requirements
Module: fp_mult_arbiter

Interface
REQ-001 SHALL have parameters: pNumReq, default 4, requester count (2..7); pWidthExp, default 11, exponent width; pWidthMan, default 52, mantissa width; pPipeline, default 5, multiplier latency in cycles (1..6). W = pWidthExp+pWidthMan+1.
REQ-002 SHALL use one clock; reset is synchronous and active-low. Ports:
- i_Clk  in  1  clock, all logic on rising edge
- i_RstN  in  1  synchronous active-low reset
- iv_ReqValid  in  pNumReq  per-requester operation valid
- ov_ReqReady  out  pNumReq  per-requester accept, one-hot or zero
- iv_ReqA  in  pNumReq*W  packed operand A per requester
- iv_ReqB  in  pNumReq*W  packed operand B per requester
- ov_MultA / ov_MultB  out  W  operands to multiplier
- o_MultDv  out  1  operand valid to multiplier
- i3_MultInID  in  3  ID the multiplier assigned to the operation issued this cycle
- iv_MultResult  in  W  multiplier product
- i3_MultOutID  in  3  ID of the product on iv_MultResult; 0 = none
- i_MultOf / i_MultUf / i_MultNaN  in  1  multiplier flags, aligned with iv_MultResult
- ov_RspValid  out  pNumReq  one-hot response strobe
- ov_RspData  out  W  product, shared bus
- o_RspOf / o_RspUf / o_RspNaN  out  1  flags aligned with ov_RspData
- i_Flush  in  1  level request to stop issuing and drain
- o_FlushDone  out  1  high while drained in DONE
- o_IdErr  out  1  one-cycle pulse on a result with an unmapped ID
- o3_Outstanding  out  3  operations in flight

Function
REQ-003 Transfer SHALL occur when iv_ReqValid[k] & ov_ReqReady[k]; ov_ReqReady SHALL be combinational, at most one bit set.
REQ-004 ov_ReqReady SHALL be all-zero unless state is RUN and o3_Outstanding < 7.
REQ-005 Grant SHALL be round-robin: search starts at the index after the last granted requester, wrapping pNumReq-1 -> 0; pointer starts at 0.
REQ-006 The cycle after a transfer from k, o_MultDv SHALL be 1 and ov_MultA/B SHALL hold k's operands; otherwise o_MultDv = 0 and ov_MultA/B hold their last value.
REQ-007 While o_MultDv = 1, the block SHALL store k in a 7-entry tag table at index i3_MultInID and mark it valid; i3_MultInID = 0 while o_MultDv = 1 SHALL pulse o_IdErr.
REQ-008 When i3_MultOutID != 0 and the entry is valid, the next cycle SHALL drive ov_RspValid = one-hot(entry), ov_RspData = iv_MultResult, flags registered, and clear the entry.
REQ-009 When i3_MultOutID != 0 and the entry is invalid, the block SHALL pulse o_IdErr the next cycle, keep ov_RspValid = 0, and leave o3_Outstanding unchanged.
REQ-010 End-to-end latency, transfer to ov_RspValid, SHALL be pPipeline+2 cycles; requesters SHALL NOT be back-pressured on responses.
REQ-011 o3_Outstanding SHALL increment on transfer and decrement on a valid response; simultaneous events leave it unchanged; it never exceeds 7 or underflows.
REQ-012 States: RUN -> DRAIN when i_Flush = 1; DRAIN -> DONE when o3_Outstanding = 0 and o_MultDv = 0; DONE -> RUN when i_Flush = 0. A transfer in the cycle i_Flush rises SHALL be blocked.
REQ-013 o_FlushDone SHALL be 1 only in DONE; responses SHALL keep routing in DRAIN.

Reset
REQ-014 With i_RstN = 0 at a clock edge: state RUN, RR pointer 0, tag table all invalid, o3_Outstanding 0, o_MultDv 0, ov_MultA/B 0, ov_RspValid 0, ov_RspData 0, all flags 0, o_IdErr 0, o_FlushDone 0.
REQ-015 Reset mid-operation SHALL discard in-flight tags; results returning after reset SHALL raise o_IdErr and not be routed.

Configuration
REQ-016 Macro FP_MULT_ARB_FIXED_PRIO_EN: when defined, grant SHALL be fixed priority (lowest index wins) and the RR pointer SHALL not exist; when undefined, round-robin per REQ-005.

Verification
REQ-017 Reset, then req0 valid with A=3FF0000000000000, B=3FF8000000000000, pPipeline=5 -> ov_RspValid=0001 exactly 7 cycles after transfer, ov_RspData=3FF8000000000000.
REQ-018 All 4 requesters valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; each ov_RspValid bit pulses twice in grant order.
REQ-019 Multiplier stub delaying results so 7 in flight -> ov_ReqReady=0 while o3_Outstanding=7; resumes the cycle after the first response.
REQ-020 i_Flush raised with 3 in flight -> no new transfers, 3 responses delivered, o_FlushDone=1 once count reaches 0; i_Flush low -> RUN, grants resume.
REQ-021 Inject i3_MultOutID=5 with no entry for tag 5 -> o_IdErr one-cycle pulse, ov_RspValid=0, o3_Outstanding unchanged.
REQ-022 With FP_MULT_ARB_FIXED_PRIO_EN defined and req0/req2 always valid -> req0 granted every cycle, req2 never.
